lsu_dc1_arb: RTL and testbench
==============================

// Module: lsu_dc1_arb
// PURPOSE
// - Arbitrates between the core LSU pipe and the DMA slave for the single DC1 address-check/DCCM port.
// - Forms start/end addresses for the selected request.
// - Holds the grant across downstream back-pressure and bounds DMA starvation with a wait counter.
// - DMA requests that fail the DCCM/PIC address check are absorbed here and answered with an error pulse; they are never forwarded.
// PARAMETERS
// - DMA_MAX_WAIT  7  consecutive cycles a pending DMA may lose before it is forced to win (1..2^CNT_W-1)
// - CNT_W         3  width of the DMA wait counter
// PORTS
// - clk             in   1   core clock; sole clock of the block
// - rst             in   1   synchronous reset, active-high
// - lsu_freeze      in   1   1 = pipe frozen: no handshakes, all state held
// - core_valid      in   1   core request pending
// - core_ready      out  1   core request accepted this cycle
// - core_addr       in   32  core start address
// - core_size       in   2   0 = byte, 1 = half, 2 = word; 3 is illegal
// - dma_valid       in   1   DMA request pending
// - dma_ready       out  1   DMA request accepted this cycle (forwarded or errored)
// - dma_addr        in   32  DMA start address
// - dma_size        in   2   same encoding as core_size
// - dc1_valid       out  1   selected request valid toward DC1
// - dc1_ready       in   1   DC1 accepts the request
// - dc1_dma         out  1   selected request is DMA
// - dc1_start_addr  out  32  start address of the selected request
// - dc1_end_addr    out  32  end address of the selected request
// - dc1_size        out  2   size of the selected request
// - dc1_dma_addr_ok in   1   address checker result for dc1_start/end_addr (in DCCM or PIC), same cycle
// - dma_err_valid   out  1   one-cycle pulse: the DMA accepted last cycle failed the address check
// BEHAVIOUR
// - Reset values: state = ARB, wait_cnt = 0, dma_err_valid = 0. All ready/valid outputs are 0 while rst = 1.
// - End address: dc1_end_addr = dc1_start_addr + (1 << size) - 1, 32-bit modulo (wraps at 0xFFFF_FFFF).
// - Selection in ARB, evaluated combinationally each cycle:
//   - DMA wins if dma_valid & (~core_valid | wait_cnt == DMA_MAX_WAIT).
//   - Otherwise core wins if core_valid.
//   - Otherwise nothing is selected and dc1_valid = 0.
// - DMA gating: dc1_valid = sel_valid & (~sel_dma | dc1_dma_addr_ok).
// - Accept rules:
//   - Core accepted: core selected & dc1_ready.
//   - DMA accepted: DMA selected & (dc1_ready | ~dc1_dma_addr_ok). A bad-address DMA is consumed without a DC1 handshake.
// - dma_err_valid is registered; it is 1 in the cycle after a DMA accept with dc1_dma_addr_ok = 0, otherwise 0.
// - Lock states (no combinational path from dc1_ready to the selection):
//   - ARB -> LOCK_CORE when core is selected & dc1_valid & ~dc1_ready.
//   - ARB -> LOCK_DMA when DMA is selected & dc1_valid & ~dc1_ready.
//   - LOCK_x forces selection to requester x regardless of the other requester or wait_cnt.
//   - LOCK_x -> ARB on the accept of x.
//   - Requesters must hold valid and request fields stable until ready. A drop of valid while locked returns the block to ARB next cycle with no accept.
// - wait_cnt:
//   - +1 in each unfrozen cycle with dma_valid & ~DMA accept, saturating at DMA_MAX_WAIT.
//   - Cleared to 0 on DMA accept or when dma_valid = 0.
// - Freeze: lsu_freeze = 1 forces core_ready = dma_ready = dc1_valid = 0. State and wait_cnt hold. dma_err_valid still clears after its single pulse.
// - Simultaneous events:
//   - Both requesters valid with wait_cnt < max: core wins and wait_cnt increments.
//   - At max, DMA wins even if the core has waited; the core has no counter.
// - Reset mid-operation: a locked request is dropped with no ready. The next cycle starts in ARB with wait_cnt = 0.
// - Illegal size 3 is treated as word for end address; no error is flagged.
// TESTING
// - Core only: addr 0xF004_0002, size 1, dc1_ready = 1 -> same-cycle dc1_valid, end 0xF004_0003, core_ready = 1, dc1_dma = 0.
// - Starvation: core_valid and dma_valid held high, dc1_ready = 1 -> core wins 7 cycles, DMA wins in the 8th, wait_cnt returns to 0.
// - Back-pressure: core selected, dc1_ready = 0 for 3 cycles while DMA is at max wait -> grant stays core (LOCK_CORE), core_ready on the 4th, DMA wins the next cycle.
// - Bad DMA: dma_addr 0x0000_1000, dc1_dma_addr_ok = 0 -> dc1_valid = 0, dma_ready = 1, dma_err_valid = 1 the following cycle only.
// - Freeze and reset: lsu_freeze = 1 for 2 cycles with both valid -> no readies, wait_cnt unchanged. Then rst = 1 in LOCK_DMA -> next cycle ARB, wait_cnt = 0, no dma_ready.
// - Wrap: core addr 0xFFFF_FFFE, size 2 -> dc1_end_addr = 0x0000_0001.

Source files
------------

// File: rtl/lsu_dc1_arb.sv
// DC1 port arbiter: selects between the core LSU pipe and the DMA slave,
// forms start/end addresses, holds grants under back-pressure and bounds DMA starvation.
module lsu_dc1_arb #(
  parameter int unsigned DMA_MAX_WAIT = 7,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_freeze,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_size,
  input  logic        dma_valid,
  output logic        dma_ready,
  input  logic [31:0] dma_addr,
  input  logic [1:0]  dma_size,
  output logic        dc1_valid,
  input  logic        dc1_ready,
  output logic        dc1_dma,
  output logic [31:0] dc1_start_addr,
  output logic [31:0] dc1_end_addr,
  output logic [1:0]  dc1_size,
  input  logic        dc1_dma_addr_ok,
  output logic        dma_err_valid
);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOCK_CORE = 2'd1,
    LOCK_DMA  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DMA_MAX_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             dma_err_q, dma_err_d;

  logic sel_core;
  logic sel_dma;
  logic live;
  logic core_acc;
  logic dma_acc;

  // Last byte covered by an access; size 3 is treated as a word.
  function automatic logic [31:0] end_addr(input logic [31:0] start, input logic [1:0] size);
    logic [31:0] span;
    case (size)
      2'd0:    span = 32'd0;
      2'd1:    span = 32'd1;
      default: span = 32'd3;
    endcase
    return start + span;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      wait_cnt_q <= '0;
      dma_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dma_err_q  <= dma_err_d;
    end
  end

  // Lock transitions depend on dc1_ready only through the registered state.
  always_comb begin
    state_d = state_q;
    if (!lsu_freeze) begin
      case (state_q)
        ARB: begin
          if (dc1_valid && !dc1_ready) state_d = sel_dma ? LOCK_DMA : LOCK_CORE;
        end
        LOCK_CORE: begin
          if (!core_valid || core_acc) state_d = ARB;
        end
        LOCK_DMA: begin
          if (!dma_valid || dma_acc) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!lsu_freeze) begin
      if (!dma_valid || dma_acc)   wait_cnt_d = '0;
      else if (wait_cnt_q < MAX_CNT) wait_cnt_d = wait_cnt_q + 1'b1;
    end
    dma_err_d = dma_acc & ~dc1_dma_addr_ok;
  end

  always_comb begin
    sel_core = 1'b0;
    sel_dma  = 1'b0;
    case (state_q)
      LOCK_CORE: sel_core = core_valid;
      LOCK_DMA:  sel_dma  = dma_valid;
      default: begin
        sel_dma  = dma_valid & (~core_valid | (wait_cnt_q == MAX_CNT));
        sel_core = core_valid & ~sel_dma;
      end
    endcase

    live     = ~rst & ~lsu_freeze;
    // A DMA failing the address check is consumed here without a DC1 handshake.
    core_acc = live & sel_core & dc1_ready;
    dma_acc  = live & sel_dma & (dc1_ready | ~dc1_dma_addr_ok);

    core_ready     = core_acc;
    dma_ready      = dma_acc;
    dc1_valid      = live & (sel_core | (sel_dma & dc1_dma_addr_ok));
    dc1_dma        = sel_dma;
    dc1_start_addr = sel_dma ? dma_addr : core_addr;
    dc1_size       = sel_dma ? dma_size : core_size;
    dc1_end_addr   = end_addr(dc1_start_addr, dc1_size);
    dma_err_valid  = dma_err_q;
  end

endmodule

// File: tb/tb_lsu_dc1_arb.sv
// Bench for lsu_dc1_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_lsu_dc1_arb;

  localparam int MAXW = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_freeze;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] core_addr;
  logic [1:0]  core_size;
  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [1:0]  dma_size;
  logic        dc1_valid;
  logic        dc1_ready;
  logic        dc1_dma;
  logic [31:0] dc1_start_addr;
  logic [31:0] dc1_end_addr;
  logic [1:0]  dc1_size;
  logic        dc1_dma_addr_ok;
  logic        dma_err_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: who owns a held grant (0 none, 1 core, 2 dma), how long DMA has lost, pending error pulse.
  int   m_owner = 0;
  int   m_wait  = 0;
  logic m_err   = 1'b0;

  lsu_dc1_arb #(.DMA_MAX_WAIT(MAXW), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .lsu_freeze(lsu_freeze),
    .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr), .core_size(core_size),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr), .dma_size(dma_size),
    .dc1_valid(dc1_valid), .dc1_ready(dc1_ready), .dc1_dma(dc1_dma),
    .dc1_start_addr(dc1_start_addr), .dc1_end_addr(dc1_end_addr), .dc1_size(dc1_size),
    .dc1_dma_addr_ok(dc1_dma_addr_ok), .dma_err_valid(dma_err_valid)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    if (m_owner == 1) return core_valid ? 1 : 0;
    if (m_owner == 2) return dma_valid ? 2 : 0;
    if (dma_valid && (!core_valid || m_wait >= MAXW)) return 2;
    return core_valid ? 1 : 0;
  endfunction

  // {core_ready, dma_ready, dc1_valid, dma_err_valid}
  function automatic logic [3:0] m_ctl();
    int   g;
    logic live, cr, dr, v;
    g    = m_grant();
    live = !rst && !lsu_freeze;
    v    = live && (g == 1 || (g == 2 && dc1_dma_addr_ok));
    cr   = live && g == 1 && dc1_ready;
    dr   = live && g == 2 && (dc1_ready || !dc1_dma_addr_ok);
    return {cr, dr, v, m_err};
  endfunction

  // {dc1_dma, dc1_size, dc1_start_addr, dc1_end_addr}
  function automatic logic [66:0] m_data();
    int          g, nbytes;
    logic [31:0] a;
    logic [1:0]  s;
    g      = m_grant();
    a      = (g == 2) ? dma_addr : core_addr;
    s      = (g == 2) ? dma_size : core_size;
    nbytes = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    return {(g == 2), s, a, a + 32'(nbytes) - 32'd1};
  endfunction

  task automatic tick();
    logic [3:0] c;
    int         g;
    c = m_ctl();
    g = m_grant();
    @(posedge clk);
    if (rst) begin
      m_owner = 0;
      m_wait  = 0;
      m_err   = 1'b0;
    end else begin
      m_err = c[2] && !dc1_dma_addr_ok;
      if (!lsu_freeze) begin
        if (m_owner == 0) begin
          if (c[1] && !dc1_ready) m_owner = g;
        end else if (g == 0 || c[3] || c[2]) begin
          m_owner = 0;
        end
        if (!dma_valid || c[2]) m_wait = 0;
        else if (m_wait < MAXW) m_wait++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    core_valid = 1'b0; dma_valid = 1'b0; dc1_ready = 1'b0; dc1_dma_addr_ok = 1'b1;
    lsu_freeze = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; core_valid = 1'b1; dma_valid = 1'b1; dc1_ready = 1'b1; dc1_dma_addr_ok = 1'b1;
    tick();
    #1;
    n_checks++;
    if ({core_ready, dma_ready, dc1_valid, dma_err_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=%b", {core_ready, dma_ready, dc1_valid, dma_err_valid}, 4'b0000);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if ({core_ready, dma_ready, dc1_valid, dma_err_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL post_reset_idle got=%b exp=%b", {core_ready, dma_ready, dc1_valid, dma_err_valid}, 4'b0000);
    end
    tick();
  endtask

  task automatic test_core_only();
    core_valid = 1'b1; core_addr = 32'hF004_0002; core_size = 2'd1;
    dma_valid = 1'b0; dc1_ready = 1'b1;
    #1;
    n_checks++;
    if ({core_ready, dma_ready, dc1_valid, dc1_dma} !== 4'b1010) begin
      n_fail++; $display("FAIL core_only_ctl got=%b exp=%b", {core_ready, dma_ready, dc1_valid, dc1_dma}, 4'b1010);
    end
    n_checks++;
    if (dc1_end_addr !== 32'hF004_0003 || dc1_start_addr !== 32'hF004_0002) begin
      n_fail++; $display("FAIL core_only_addr got=%h/%h exp=f0040002/f0040003", dc1_start_addr, dc1_end_addr);
    end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    core_valid = 1'b1; core_addr = 32'h0000_0100; core_size = 2'd2;
    dma_valid = 1'b1; dma_addr = 32'h0000_0200; dma_size = 2'd2;
    dc1_ready = 1'b1; dc1_dma_addr_ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [3:0] exp;
      exp = (i == 7) ? 4'b0111 : 4'b1010;
      #1;
      n_checks++;
      if ({core_ready, dma_ready, dc1_valid, dc1_dma} !== exp) begin
        n_fail++; $display("FAIL starvation_cyc%0d got=%b exp=%b", i, {core_ready, dma_ready, dc1_valid, dc1_dma}, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_back_pressure();
    core_valid = 1'b1; core_addr = 32'h0000_0400; core_size = 2'd0;
    dma_valid = 1'b1; dma_addr = 32'h0000_0800; dma_size = 2'd1;
    dc1_dma_addr_ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      logic [3:0] exp;
      dc1_ready = !(i >= 6 && i <= 8);
      if (i >= 6 && i <= 8) exp = 4'b0010;
      else if (i == 10)     exp = 4'b0111;
      else                  exp = 4'b1010;
      #1;
      n_checks++;
      if ({core_ready, dma_ready, dc1_valid, dc1_dma} !== exp) begin
        n_fail++; $display("FAIL back_pressure_cyc%0d got=%b exp=%b", i, {core_ready, dma_ready, dc1_valid, dc1_dma}, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_bad_dma();
    core_valid = 1'b0; dma_valid = 1'b1; dma_addr = 32'h0000_1000; dma_size = 2'd2;
    dc1_dma_addr_ok = 1'b0; dc1_ready = 1'b0;
    #1;
    n_checks++;
    if ({core_ready, dma_ready, dc1_valid, dma_err_valid} !== 4'b0100) begin
      n_fail++; $display("FAIL bad_dma_accept got=%b exp=%b", {core_ready, dma_ready, dc1_valid, dma_err_valid}, 4'b0100);
    end
    tick();
    dma_valid = 1'b0; dc1_dma_addr_ok = 1'b1;
    #1;
    n_checks++;
    if ({core_ready, dma_ready, dc1_valid, dma_err_valid} !== 4'b0001) begin
      n_fail++; $display("FAIL bad_dma_err_pulse got=%b exp=%b", {core_ready, dma_ready, dc1_valid, dma_err_valid}, 4'b0001);
    end
    tick();
    #1;
    n_checks++;
    if (dma_err_valid !== 1'b0) begin
      n_fail++; $display("FAIL bad_dma_err_clear got=%b exp=0", dma_err_valid);
    end
    tick();
  endtask

  task automatic test_freeze_reset();
    int   wins;
    logic got_dma;
    core_valid = 1'b1; core_addr = 32'h0000_2000; core_size = 2'd2;
    dma_valid = 1'b1; dma_addr = 32'h0000_3000; dma_size = 2'd2;
    dc1_ready = 1'b1; dc1_dma_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    lsu_freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({core_ready, dma_ready, dc1_valid} !== 3'b000) begin
        n_fail++; $display("FAIL freeze_cyc%0d got=%b exp=000", i, {core_ready, dma_ready, dc1_valid});
      end
      tick();
    end
    lsu_freeze = 1'b0;
    wins = 0; got_dma = 1'b0;
    for (int i = 0; i < 10 && !got_dma; i++) begin
      #1;
      if (dma_ready) got_dma = 1'b1;
      else if (core_ready) wins++;
      tick();
    end
    n_checks++;
    if (!got_dma || wins != 4) begin
      n_fail++; $display("FAIL freeze_hold_wait got=%0d core wins (dma=%b) exp=4 (dma=1)", wins, got_dma);
    end
    core_valid = 1'b0; dc1_ready = 1'b0;
    tick();
    rst = 1'b1; dc1_ready = 1'b1;
    #1;
    n_checks++;
    if ({core_ready, dma_ready, dc1_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_in_lock got=%b exp=000", {core_ready, dma_ready, dc1_valid});
    end
    tick();
    rst = 1'b0; core_valid = 1'b1; dc1_ready = 1'b0;
    #1;
    n_checks++;
    if ({dc1_valid, dc1_dma, dma_err_valid} !== 3'b100) begin
      n_fail++; $display("FAIL after_reset_arb got=%b exp=100", {dc1_valid, dc1_dma, dma_err_valid});
    end
    tick();
    idle();
  endtask

  task automatic test_wrap();
    core_valid = 1'b1; core_addr = 32'hFFFF_FFFE; core_size = 2'd2;
    dma_valid = 1'b0; dc1_ready = 1'b1;
    #1;
    n_checks++;
    if (dc1_end_addr !== 32'h0000_0001) begin
      n_fail++; $display("FAIL wrap_word got=%h exp=00000001", dc1_end_addr);
    end
    core_size = 2'd3;
    #1;
    n_checks++;
    if (dc1_end_addr !== 32'h0000_0001) begin
      n_fail++; $display("FAIL wrap_size3 got=%h exp=00000001", dc1_end_addr);
    end
    core_valid = 1'b0; dma_valid = 1'b1; dma_addr = 32'hFFFF_FFFF; dma_size = 2'd1;
    #1;
    n_checks++;
    if (dc1_end_addr !== 32'h0000_0000 || dc1_dma !== 1'b1) begin
      n_fail++; $display("FAIL wrap_dma_half got=%h dma=%b exp=00000000 dma=1", dc1_end_addr, dc1_dma);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [3:0]  exp_c;
    logic [66:0] exp_d;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      lsu_freeze = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) core_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) dma_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        core_addr = $urandom;
        if ($urandom_range(0, 5) == 0) core_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        core_size = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0) begin
        dma_addr = $urandom;
        if ($urandom_range(0, 5) == 0) dma_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        dma_size = 2'($urandom_range(0, 3));
      end
      dc1_ready       = $urandom_range(0, 1) == 1;
      dc1_dma_addr_ok = $urandom_range(0, 3) != 0;
      #1;
      exp_c = m_ctl();
      n_checks++;
      if ({core_ready, dma_ready, dc1_valid, dma_err_valid} !== exp_c) begin
        n_fail++; $display("FAIL rand_ctl cyc%0d got=%b exp=%b", i, {core_ready, dma_ready, dc1_valid, dma_err_valid}, exp_c);
      end
      if (!rst && m_grant() != 0) begin
        exp_d = m_data();
        n_checks++;
        if ({dc1_dma, dc1_size, dc1_start_addr, dc1_end_addr} !== exp_d) begin
          n_fail++; $display("FAIL rand_data cyc%0d got=%h exp=%h", i, {dc1_dma, dc1_size, dc1_start_addr, dc1_end_addr}, exp_d);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; lsu_freeze = 1'b0;
    core_valid = 1'b0; core_addr = '0; core_size = '0;
    dma_valid = 1'b0; dma_addr = '0; dma_size = '0;
    dc1_ready = 1'b0; dc1_dma_addr_ok = 1'b1;
    @(negedge clk);
    test_reset();
    test_core_only();
    test_starvation();
    test_back_pressure();
    test_bad_dma();
    test_freeze_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
